// File: rtl/pwm_multi_pkg.sv
// Shared types and constants for the multi-channel PWM generator.
package pwm_multi_pkg;

    // Per-channel dead-time FSM states.
    typedef enum logic [1:0] {
        LOW     = 2'd0,
        DT_RISE = 2'd1,
        HIGH    = 2'd2,
        DT_FALL = 2'd3
    } dt_state_t;

    // Gate-drive pair for one channel (high side, low side).
    typedef struct packed {
        logic ctrl;
        logic ctrl_n;
    } gate_t;

    // Both switches off: reset, disabled and dead-time intervals.
    localparam gate_t GATE_SAFE = '{ctrl: 1'b0, ctrl_n: 1'b0};
    // Low side conducting.
    localparam gate_t GATE_LOW  = '{ctrl: 1'b0, ctrl_n: 1'b1};
    // High side conducting.
    localparam gate_t GATE_HIGH = '{ctrl: 1'b1, ctrl_n: 1'b0};

endpackage

// File: rtl/pwm_deadtime.sv
// Per-channel dead-time inserter: turns the raw PWM level into a
// non-overlapping complementary gate pair.
module pwm_deadtime
    import pwm_multi_pkg::*;
#(
    parameter int DT_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            raw,
    input  logic [DT_W-1:0] dead_s,
    output logic            ctrl,
    output logic            ctrl_n
);

    dt_state_t       state_q;
    logic [DT_W-1:0] dt_cnt_q;
    gate_t           gate_q;
    logic            dt_done;

    // The counter is 1 on entry to a dead-time state, so it has served
    // dt_cnt_q clocks when compared here.
    assign dt_done = (dt_cnt_q >= dead_s);

    // Dead-time FSM; gate outputs are registered together with the state
    // they belong to, so the two sides can never overlap.
    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values and simulation matches the synthesized registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= LOW;
            dt_cnt_q <= '0;
            gate_q   <= GATE_SAFE;
        end else if (!en) begin
            state_q  <= LOW;
            dt_cnt_q <= '0;
            gate_q   <= GATE_SAFE;
        end else begin
            unique case (state_q)
                LOW: begin
                    if (!raw) begin
                        gate_q <= GATE_LOW;
                    end else if (dead_s == '0) begin
                        state_q <= HIGH;
                        gate_q  <= GATE_HIGH;
                    end else begin
                        state_q  <= DT_RISE;
                        dt_cnt_q <= DT_W'(1);
                        gate_q   <= GATE_SAFE;
                    end
                end
                DT_RISE: begin
                    if (!raw) begin
                        // Pulse shorter than the dead time is swallowed.
                        state_q <= LOW;
                        gate_q  <= GATE_LOW;
                    end else if (dt_done) begin
                        state_q <= HIGH;
                        gate_q  <= GATE_HIGH;
                    end else begin
                        dt_cnt_q <= dt_cnt_q + DT_W'(1);
                    end
                end
                HIGH: begin
                    if (raw) begin
                        gate_q <= GATE_HIGH;
                    end else if (dead_s == '0) begin
                        state_q <= LOW;
                        gate_q  <= GATE_LOW;
                    end else begin
                        state_q  <= DT_FALL;
                        dt_cnt_q <= DT_W'(1);
                        gate_q   <= GATE_SAFE;
                    end
                end
                DT_FALL: begin
                    if (raw) begin
                        state_q <= HIGH;
                        gate_q  <= GATE_HIGH;
                    end else if (dt_done) begin
                        state_q <= LOW;
                        gate_q  <= GATE_LOW;
                    end else begin
                        dt_cnt_q <= dt_cnt_q + DT_W'(1);
                    end
                end
            endcase
        end
    end

    assign ctrl   = gate_q.ctrl;
    assign ctrl_n = gate_q.ctrl_n;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: shared master counter, shadowed period,
// duty, phase and dead time, and one dead-time inserter per channel.
module pwm_multi
    import pwm_multi_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16,
    parameter int DT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [CNT_W-1:0]      period,
    input  logic [N_CH*CNT_W-1:0] duty,
    input  logic [N_CH*CNT_W-1:0] phase,
    input  logic [DT_W-1:0]       dead,
    input  logic                  load,
    output logic                  loaded,
    output logic                  sync,
    output logic [N_CH-1:0]       ctrl,
    output logic [N_CH-1:0]       ctrl_n
);

    localparam logic [CNT_W:0] ONE_X = (CNT_W + 1)'(1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      period_s_q, period_s_d;
    logic [N_CH*CNT_W-1:0] duty_s_q, duty_s_d;
    logic [N_CH*CNT_W-1:0] phase_s_q, phase_s_d;
    logic [DT_W-1:0]       dead_s_q, dead_s_d;
    logic                  pend_q, pend_d;
    logic                  loaded_q, loaded_d;
    logic                  en_q;
    logic [N_CH-1:0]       raw_q, raw_d;

    logic running;
    logic en_rise;
    logic at_end;
    logic shadow_wr;

    // Counting only starts the cycle after en rises; that first cycle is
    // used to take a fresh copy of the live settings.
    assign running   = en & en_q;
    assign en_rise   = en & ~en_q;
    assign at_end    = (cnt_q == period_s_q);
    assign sync      = running & at_end;
    assign shadow_wr = en_rise | (sync & (pend_q | load));

    // Master counter, shadow registers and load handshake.
    // NOTE: every variable gets a default before any condition, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d      = cnt_q + CNT_W'(1);
        period_s_d = period_s_q;
        duty_s_d   = duty_s_q;
        phase_s_d  = phase_s_q;
        dead_s_d   = dead_s_q;
        pend_d     = pend_q;
        loaded_d   = shadow_wr;

        if (!running || at_end) begin
            cnt_d = '0;
        end

        if (shadow_wr) begin
            period_s_d = period;
            duty_s_d   = duty;
            phase_s_d  = phase;
            dead_s_d   = dead;
        end

        if (!en || shadow_wr) begin
            pend_d = 1'b0;
        end else if (load) begin
            pend_d = 1'b1;
        end
    end

    // Per-channel phase-shifted local count and duty compare.
    always_comb begin
        logic [CNT_W-1:0] ph;
        logic [CNT_W:0]   loc;
        raw_d = '0;
        ph    = '0;
        loc   = '0;
        for (int i = 0; i < N_CH; i++) begin
            ph = phase_s_q[i*CNT_W +: CNT_W];
            if (ph > period_s_q) begin
                ph = '0;
            end
            loc = {1'b0, cnt_q} + {1'b0, ph};
            if (loc > {1'b0, period_s_q}) begin
                loc = loc - ({1'b0, period_s_q} + ONE_X);
            end
            raw_d[i] = running & (loc < {1'b0, duty_s_q[i*CNT_W +: CNT_W]});
        end
    end

    // State registers for the counter, shadows and raw waveforms.
    // NOTE: shadow registers are reset like any other flop: a defined
    // period/duty after reset keeps the raw compare from seeing X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            period_s_q <= '0;
            duty_s_q   <= '0;
            phase_s_q  <= '0;
            dead_s_q   <= '0;
            pend_q     <= 1'b0;
            loaded_q   <= 1'b0;
            en_q       <= 1'b0;
            raw_q      <= '0;
        end else begin
            cnt_q      <= cnt_d;
            period_s_q <= period_s_d;
            duty_s_q   <= duty_s_d;
            phase_s_q  <= phase_s_d;
            dead_s_q   <= dead_s_d;
            pend_q     <= pend_d;
            loaded_q   <= loaded_d;
            en_q       <= en;
            raw_q      <= raw_d;
        end
    end

    assign loaded = loaded_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        pwm_deadtime #(
            .DT_W(DT_W)
        ) u_dt (
            .clk   (clk),
            .rst   (rst),
            .en    (en),
            .raw   (raw_q[g]),
            .dead_s(dead_s_q),
            .ctrl  (ctrl[g]),
            .ctrl_n(ctrl_n[g])
        );
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi against a cycle-level behavioural model.
module tb_pwm_multi;

    localparam int N_CH  = 4;
    localparam int CNT_W = 16;
    localparam int DT_W  = 8;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  en = 1'b0;
    logic                  load = 1'b0;
    logic [CNT_W-1:0]      period = '0;
    logic [N_CH*CNT_W-1:0] duty = '0;
    logic [N_CH*CNT_W-1:0] phase = '0;
    logic [DT_W-1:0]       dead = '0;
    logic                  loaded, sync;
    logic [N_CH-1:0]       ctrl, ctrl_n;

    int errors = 0;
    int checks = 0;

    // Model state: counter and shadows as plain integers, per channel the
    // committed output level and how long raw has disagreed with it.
    int              m_cnt, m_per, m_dead;
    int              m_duty [N_CH];
    int              m_phase[N_CH];
    int              m_streak[N_CH];
    bit              m_raw[N_CH];
    bit              m_lvl[N_CH];
    bit              m_pend, m_en_prev;
    logic            m_loaded;
    logic [N_CH-1:0] m_ctrl, m_ctrl_n;

    always #5 clk = ~clk;

    pwm_multi #(.N_CH(N_CH), .CNT_W(CNT_W), .DT_W(DT_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .period(period),
        .duty  (duty),
        .phase (phase),
        .dead  (dead),
        .load  (load),
        .loaded(loaded),
        .sync  (sync),
        .ctrl  (ctrl),
        .ctrl_n(ctrl_n)
    );

    task automatic model_reset();
        m_cnt = 0; m_per = 0; m_dead = 0;
        m_pend = 0; m_en_prev = 0; m_loaded = 0;
        m_ctrl = '0; m_ctrl_n = '0;
        for (int i = 0; i < N_CH; i++) begin
            m_duty[i] = 0; m_phase[i] = 0; m_streak[i] = 0;
            m_raw[i] = 0; m_lvl[i] = 0;
        end
    endtask

    // One clock edge of the reference behaviour, using the inputs held
    // across that edge.
    task automatic model_edge();
        bit running, rise, wr;
        int ph;
        running = en && m_en_prev;
        rise    = en && !m_en_prev;
        wr      = rise || (running && m_cnt == m_per && (m_pend || load));
        for (int i = 0; i < N_CH; i++) begin
            if (!en) begin
                m_lvl[i] = 0; m_streak[i] = 0; m_ctrl[i] = 0; m_ctrl_n[i] = 0;
            end else if (m_raw[i] == m_lvl[i]) begin
                m_streak[i] = 0; m_ctrl[i] = m_lvl[i]; m_ctrl_n[i] = !m_lvl[i];
            end else begin
                m_streak[i]++;
                if (m_streak[i] > m_dead) begin
                    m_lvl[i] = m_raw[i]; m_streak[i] = 0;
                    m_ctrl[i] = m_lvl[i]; m_ctrl_n[i] = !m_lvl[i];
                end else begin
                    m_ctrl[i] = 0; m_ctrl_n[i] = 0;
                end
            end
            ph = (m_phase[i] > m_per) ? 0 : m_phase[i];
            m_raw[i] = running && (((m_cnt + ph) % (m_per + 1)) < m_duty[i]);
        end
        m_cnt = (running && m_cnt != m_per) ? m_cnt + 1 : 0;
        if (wr) begin
            m_per  = int'(period);
            m_dead = int'(dead);
            for (int i = 0; i < N_CH; i++) begin
                m_duty[i]  = int'(duty[i*CNT_W +: CNT_W]);
                m_phase[i] = int'(phase[i*CNT_W +: CNT_W]);
            end
        end
        if (!en || wr) m_pend = 0;
        else if (load) m_pend = 1;
        m_loaded  = wr;
        m_en_prev = en;
    endtask

    function automatic logic exp_sync();
        return en && m_en_prev && (m_cnt == m_per);
    endfunction

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        @(negedge clk);
    endtask

    task automatic set_cfg(input int p, input int d[N_CH], input int ph[N_CH], input int dt);
        period = CNT_W'(p);
        for (int i = 0; i < N_CH; i++) begin
            duty[i*CNT_W +: CNT_W]  = CNT_W'(d[i]);
            phase[i*CNT_W +: CNT_W] = CNT_W'(ph[i]);
        end
        dead = DT_W'(dt);
    endtask

    task automatic restart();
        en = 1'b0;
        load = 1'b0;
        step();
        step();
        en = 1'b1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        model_reset();
        #1;
        if ({ctrl, ctrl_n, sync, loaded} !== '0) begin
            errors++;
            $display("FAIL reset_value: got ctrl=%b ctrl_n=%b sync=%b loaded=%b, want all 0", ctrl, ctrl_n, sync, loaded);
        end
        checks++;
        step();
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if ({ctrl, ctrl_n, sync, loaded} !== {m_ctrl, m_ctrl_n, exp_sync(), m_loaded}) begin
                errors++;
                $display("FAIL reset_safe @%0t: got %b %b %b %b want %b %b %b %b", $time, ctrl, ctrl_n, sync, loaded, m_ctrl, m_ctrl_n, exp_sync(), m_loaded);
            end
            checks++;
        end
    endtask

    task automatic test_basic_duty();
        int hi[N_CH];
        int exp_hi[N_CH];
        int syncs;
        exp_hi = '{10, 4, 0, 20};
        syncs = 0;
        set_cfg(9, '{5, 2, 0, 10}, '{0, 0, 0, 0}, 0);
        restart();
        for (int i = 0; i < N_CH; i++) hi[i] = 0;
        for (int k = 0; k < 24; k++) begin
            step();
            if ({ctrl, ctrl_n, sync, loaded} !== {m_ctrl, m_ctrl_n, exp_sync(), m_loaded}) begin
                errors++;
                $display("FAIL basic_model @%0t: got %b %b %b %b want %b %b %b %b", $time, ctrl, ctrl_n, sync, loaded, m_ctrl, m_ctrl_n, exp_sync(), m_loaded);
            end
            checks++;
            if (k >= 4) begin
                if (ctrl_n !== ~ctrl) begin
                    errors++;
                    $display("FAIL basic_complement @%0t: ctrl=%b ctrl_n=%b", $time, ctrl, ctrl_n);
                end
                checks++;
                for (int i = 0; i < N_CH; i++) hi[i] += int'(ctrl[i]);
                syncs += int'(sync);
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            if (hi[i] != exp_hi[i]) begin
                errors++;
                $display("FAIL basic_duty ch%0d: high %0d of 20 cycles, want %0d", i, hi[i], exp_hi[i]);
            end
            checks++;
        end
        if (syncs != 2) begin
            errors++;
            $display("FAIL basic_sync: %0d sync cycles in 20, want 2", syncs);
        end
        checks++;
    endtask

    task automatic test_phase();
        bit c0[30];
        bit c1[30];
        set_cfg(9, '{5, 5, 5, 5}, '{0, 5, 0, 0}, 0);
        restart();
        for (int k = 0; k < 34; k++) begin
            step();
            if ({ctrl, ctrl_n, sync, loaded} !== {m_ctrl, m_ctrl_n, exp_sync(), m_loaded}) begin
                errors++;
                $display("FAIL phase_model @%0t: got %b %b %b %b want %b %b %b %b", $time, ctrl, ctrl_n, sync, loaded, m_ctrl, m_ctrl_n, exp_sync(), m_loaded);
            end
            checks++;
            if (k >= 4) begin
                c0[k-4] = ctrl[0];
                c1[k-4] = ctrl[1];
            end
        end
        for (int t = 0; t < 25; t++) begin
            if (c1[t] != c0[t+5] || c1[t] == c0[t]) begin
                errors++;
                $display("FAIL phase_shift t=%0d: ctrl1=%0b ctrl0=%0b ctrl0(t+5)=%0b", t, c1[t], c0[t], c0[t+5]);
            end
            checks++;
        end
    endtask

    task automatic test_dead_time();
        int hi[N_CH];
        int lo[N_CH];
        int off[N_CH];
        set_cfg(19, '{10, 10, 10, 10}, '{0, 3, 7, 19}, 3);
        restart();
        for (int i = 0; i < N_CH; i++) begin hi[i] = 0; lo[i] = 0; off[i] = 0; end
        for (int k = 0; k < 65; k++) begin
            step();
            if ({ctrl, ctrl_n, sync, loaded} !== {m_ctrl, m_ctrl_n, exp_sync(), m_loaded}) begin
                errors++;
                $display("FAIL dead_model @%0t: got %b %b %b %b want %b %b %b %b", $time, ctrl, ctrl_n, sync, loaded, m_ctrl, m_ctrl_n, exp_sync(), m_loaded);
            end
            checks++;
            if ((ctrl & ctrl_n) !== '0) begin
                errors++;
                $display("FAIL dead_overlap @%0t: ctrl=%b ctrl_n=%b", $time, ctrl, ctrl_n);
            end
            checks++;
            if (k >= 25) begin
                for (int i = 0; i < N_CH; i++) begin
                    hi[i]  += int'(ctrl[i]);
                    lo[i]  += int'(ctrl_n[i]);
                    off[i] += int'(!ctrl[i] && !ctrl_n[i]);
                end
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            if (hi[i] != 14 || lo[i] != 14 || off[i] != 12) begin
                errors++;
                $display("FAIL dead_counts ch%0d: ctrl=%0d ctrl_n=%0d off=%0d in 40, want 14 14 12", i, hi[i], lo[i], off[i]);
            end
            checks++;
        end
    endtask

    task automatic test_swallow();
        int hi;
        int lo_n;
        set_cfg(9, '{2, 2, 2, 2}, '{0, 0, 0, 0}, 4);
        restart();
        hi = 0;
        lo_n = 0;
        for (int k = 0; k < 35; k++) begin
            step();
            if ({ctrl, ctrl_n, sync, loaded} !== {m_ctrl, m_ctrl_n, exp_sync(), m_loaded}) begin
                errors++;
                $display("FAIL swallow_model @%0t: got %b %b %b %b want %b %b %b %b", $time, ctrl, ctrl_n, sync, loaded, m_ctrl, m_ctrl_n, exp_sync(), m_loaded);
            end
            checks++;
            if (k >= 15) begin
                hi   += int'(ctrl[0]);
                lo_n += int'(!ctrl_n[0]);
            end
        end
        if (hi != 0 || lo_n != 4) begin
            errors++;
            $display("FAIL swallow_counts: ctrl high %0d, ctrl_n low %0d in 20, want 0 and 4", hi, lo_n);
        end
        checks++;
    endtask

    task automatic test_shadow_update();
        bit h[$];
        int ones;
        bit seen;
        set_cfg(9, '{3, 3, 3, 3}, '{0, 0, 0, 0}, 0);
        restart();
        for (int k = 0; k < 14; k++) begin
            step();
            h.push_back(ctrl[0]);
        end
        // Reach a sync cycle, then move 4 cycles into the next period.
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (sync) seen = 1;
            else begin step(); h.push_back(ctrl[0]); end
        end
        for (int k = 0; k < 4; k++) begin step(); h.push_back(ctrl[0]); end
        duty[0 +: CNT_W] = CNT_W'(7);
        load = 1'b1;
        step();
        h.push_back(ctrl[0]);
        load = 1'b0;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if ({ctrl, ctrl_n, sync, loaded} !== {m_ctrl, m_ctrl_n, exp_sync(), m_loaded}) begin
                errors++;
                $display("FAIL shadow_model @%0t: got %b %b %b %b want %b %b %b %b", $time, ctrl, ctrl_n, sync, loaded, m_ctrl, m_ctrl_n, exp_sync(), m_loaded);
            end
            checks++;
            if (sync) seen = 1;
            else begin step(); h.push_back(ctrl[0]); end
        end
        if (!seen || loaded !== 1'b0) begin
            errors++;
            $display("FAIL shadow_wait: sync seen=%0b loaded=%b, want 1 and 0", seen, loaded);
        end
        checks++;
        step();
        h.push_back(ctrl[0]);
        if (loaded !== 1'b1) begin
            errors++;
            $display("FAIL shadow_loaded: loaded=%b after sync cycle, want 1", loaded);
        end
        checks++;
        step();
        h.push_back(ctrl[0]);
        ones = 0;
        for (int k = h.size() - 10; k < h.size(); k++) ones += int'(h[k]);
        if (ones != 3) begin
            errors++;
            $display("FAIL shadow_old_duty: %0d high cycles in last old period, want 3", ones);
        end
        checks++;
        ones = 0;
        for (int k = 0; k < 10; k++) begin step(); ones += int'(ctrl[0]); end
        if (ones != 7) begin
            errors++;
            $display("FAIL shadow_new_duty: %0d high cycles in new period, want 7", ones);
        end
        checks++;
        // load coincident with the sync cycle applies at that very wrap.
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (sync) seen = 1;
            else step();
        end
        duty[0 +: CNT_W] = CNT_W'(1);
        load = 1'b1;
        step();
        load = 1'b0;
        if (!seen || loaded !== 1'b1) begin
            errors++;
            $display("FAIL shadow_coincident_loaded: sync seen=%0b loaded=%b, want 1 and 1", seen, loaded);
        end
        checks++;
        step();
        ones = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            ones += int'(ctrl[0]);
            if ({ctrl, ctrl_n, sync, loaded} !== {m_ctrl, m_ctrl_n, exp_sync(), m_loaded}) begin
                errors++;
                $display("FAIL shadow_coincident_model @%0t: got %b %b %b %b want %b %b %b %b", $time, ctrl, ctrl_n, sync, loaded, m_ctrl, m_ctrl_n, exp_sync(), m_loaded);
            end
            checks++;
        end
        if (ones != 1) begin
            errors++;
            $display("FAIL shadow_coincident_duty: %0d high cycles, want 1", ones);
        end
        checks++;
    endtask

    task automatic test_reset_enable();
        bit seen;
        int ones;
        set_cfg(9, '{5, 5, 5, 5}, '{0, 0, 0, 0}, 0);
        restart();
        seen = 0;
        for (int k = 0; k < 25 && !seen; k++) begin
            step();
            if (k >= 3 && ctrl[0]) seen = 1;
        end
        if (!seen) begin
            errors++;
            $display("FAIL rst_wait_high: ctrl[0] never went high");
        end
        checks++;
        load = 1'b1;
        step();
        load = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        #1;
        if ({ctrl, ctrl_n, sync, loaded} !== '0) begin
            errors++;
            $display("FAIL rst_async: got ctrl=%b ctrl_n=%b sync=%b loaded=%b, want all 0", ctrl, ctrl_n, sync, loaded);
        end
        checks++;
        step();
        set_cfg(9, '{3, 3, 3, 3}, '{0, 0, 0, 0}, 0);
        rst = 1'b0;
        ones = 0;
        for (int k = 0; k < 14; k++) begin
            step();
            if ({ctrl, ctrl_n, sync, loaded} !== {m_ctrl, m_ctrl_n, exp_sync(), m_loaded}) begin
                errors++;
                $display("FAIL rst_restart_model @%0t: got %b %b %b %b want %b %b %b %b", $time, ctrl, ctrl_n, sync, loaded, m_ctrl, m_ctrl_n, exp_sync(), m_loaded);
            end
            checks++;
            if (k >= 4) ones += int'(ctrl[0]);
        end
        if (ones != 3) begin
            errors++;
            $display("FAIL rst_restart_duty: %0d high cycles, want 3", ones);
        end
        checks++;
        // Drop en mid-period.
        en = 1'b0;
        step();
        if (ctrl !== '0 || ctrl_n !== '0 || sync !== 1'b0 || dut.cnt_q !== '0) begin
            errors++;
            $display("FAIL en_low: ctrl=%b ctrl_n=%b sync=%b cnt=%0d, want 0 0 0 0", ctrl, ctrl_n, sync, dut.cnt_q);
        end
        checks++;
        step();
        step();
        set_cfg(9, '{2, 2, 2, 2}, '{0, 0, 0, 0}, 0);
        en = 1'b1;
        ones = 0;
        for (int k = 0; k < 13; k++) begin
            step();
            if ({ctrl, ctrl_n, sync, loaded} !== {m_ctrl, m_ctrl_n, exp_sync(), m_loaded}) begin
                errors++;
                $display("FAIL en_restart_model @%0t: got %b %b %b %b want %b %b %b %b", $time, ctrl, ctrl_n, sync, loaded, m_ctrl, m_ctrl_n, exp_sync(), m_loaded);
            end
            checks++;
            if (k >= 3) ones += int'(ctrl[0]);
        end
        if (ones != 2) begin
            errors++;
            $display("FAIL en_restart_duty: %0d high cycles, want 2", ones);
        end
        checks++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int p;
            int d[N_CH];
            int ph[N_CH];
            p = $urandom_range(2, 15);
            for (int i = 0; i < N_CH; i++) begin
                d[i]  = $urandom_range(0, p + 2);
                ph[i] = $urandom_range(0, p + 2);
            end
            set_cfg(p, d, ph, $urandom_range(0, 5));
            restart();
            for (int k = 0; k < 5 * (p + 1) + 10; k++) begin
                int c;
                load = ($urandom_range(0, 7) == 0);
                c = $urandom_range(0, N_CH - 1);
                if ($urandom_range(0, 3) == 0) duty[c*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 17));
                if ($urandom_range(0, 5) == 0) phase[c*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 17));
                if ($urandom_range(0, 15) == 0) period = CNT_W'($urandom_range(0, 15));
                if ($urandom_range(0, 15) == 0) dead = DT_W'($urandom_range(0, 5));
                step();
                if ({ctrl, ctrl_n, sync, loaded} !== {m_ctrl, m_ctrl_n, exp_sync(), m_loaded}) begin
                    errors++;
                    $display("FAIL random_model it=%0d @%0t: got %b %b %b %b want %b %b %b %b", it, $time, ctrl, ctrl_n, sync, loaded, m_ctrl, m_ctrl_n, exp_sync(), m_loaded);
                end
                checks++;
                if ((ctrl & ctrl_n) !== '0) begin
                    errors++;
                    $display("FAIL random_overlap @%0t: ctrl=%b ctrl_n=%b", $time, ctrl, ctrl_n);
                end
                checks++;
            end
            load = 1'b0;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_duty();
        test_phase();
        test_dead_time();
        test_swallow();
        test_shadow_update();
        test_reset_enable();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
